// File: rtl/pipelined_adder_n.sv
// Carry-chained adder split into STAGES = WIDTH/CHUNK registered chunk adders
// with a per-stage valid/ready handshake. Stalls propagate back; bubbles collapse.
module pipelined_adder_n #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             CarryIn,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow
);
    localparam int STAGES = WIDTH / CHUNK;

    logic [STAGES-1:0] vldPipe;
    logic [STAGES-1:0] loadVec;
    logic              chainReady;
    logic              accept;

    // A stage loads when it is empty or its successor loads; walk from the output back.
    always_comb begin
        loadVec    = '0;
        chainReady = OutReady;
        for (int k = STAGES-1; k >= 0; k--) begin
            loadVec[k] = !vldPipe[k] || chainReady;
            chainReady = loadVec[k];
        end
    end

    assign InReady = ResetN && loadVec[0];
    assign accept  = InValid && InReady;

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        localparam int OPW = WIDTH - k*CHUNK;  // operand bits still to be added, incl. this chunk
        localparam int SW  = (k+1)*CHUNK;      // sum bits completed after this stage

        logic             vIn;
        logic             cIn;
        logic [OPW-1:0]   xIn;
        logic [OPW-1:0]   yIn;
        logic [SW-1:0]    sumNext;
        logic [CHUNK:0]   res;
        logic             vldR;
        logic             carryR;
        logic [SW-1:0]    sumR;

        if (k == 0) begin : gHead
            assign vIn     = accept;
            assign cIn     = CarryIn;
            assign xIn     = X;
            assign yIn     = Sub ? ~Y : Y;
            assign sumNext = res[CHUNK-1:0];
        end else begin : gBody
            assign vIn     = gStage[k-1].vldR;
            assign cIn     = gStage[k-1].carryR;
            assign xIn     = gStage[k-1].gOps.xR;
            assign yIn     = gStage[k-1].gOps.yR;
            assign sumNext = {res[CHUNK-1:0], gStage[k-1].sumR};
        end

        assign res = {1'b0, xIn[CHUNK-1:0]} + {1'b0, yIn[CHUNK-1:0]} + {{CHUNK{1'b0}}, cIn};
        assign vldPipe[k] = vldR;

        always_ff @(posedge Clock or negedge ResetN) begin
            if (!ResetN) begin
                vldR   <= 1'b0;
                carryR <= 1'b0;
                sumR   <= '0;
            end else if (loadVec[k]) begin
                vldR   <= vIn;
                carryR <= res[CHUNK];
                sumR   <= sumNext;
            end
        end

        if (k < STAGES-1) begin : gOps
            // Only the not-yet-added upper chunks travel on, shifted down to bit 0.
            logic [OPW-CHUNK-1:0] xR;
            logic [OPW-CHUNK-1:0] yR;
            always_ff @(posedge Clock or negedge ResetN) begin
                if (!ResetN) begin
                    xR <= '0;
                    yR <= '0;
                end else if (loadVec[k]) begin
                    xR <= xIn[OPW-1:CHUNK];
                    yR <= yIn[OPW-1:CHUNK];
                end
            end
        end else begin : gTail
            // Carry into the MSB is recovered from the MSB sum and operand bits.
            logic ovfR;
            always_ff @(posedge Clock or negedge ResetN) begin
                if (!ResetN) ovfR <= 1'b0;
                else if (loadVec[k])
                    ovfR <= res[CHUNK] ^ res[CHUNK-1] ^ xIn[CHUNK-1] ^ yIn[CHUNK-1];
            end
        end
    end

    assign OutValid = vldPipe[STAGES-1];
    assign Sum      = gStage[STAGES-1].sumR;
    assign CarryOut = gStage[STAGES-1].carryR;
    assign Overflow = gStage[STAGES-1].gTail.ovfR;

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Directed bench for pipelined_adder_n (WIDTH=64, CHUNK=16, four stages).
module tb_pipelined_adder_n;
    localparam int W = 64;

    logic         Clock    = 1'b0;
    logic         ResetN   = 1'b0;
    logic         InValid  = 1'b0;
    logic         InReady;
    logic [W-1:0] X        = '0;
    logic [W-1:0] Y        = '0;
    logic         CarryIn  = 1'b0;
    logic         Sub      = 1'b0;
    logic         OutValid;
    logic         OutReady = 1'b0;
    logic [W-1:0] Sum;
    logic         CarryOut;
    logic         Overflow;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    pipelined_adder_n #(.WIDTH(64), .CHUNK(16)) dut (
        .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .X(X), .Y(Y), .CarryIn(CarryIn), .Sub(Sub),
        .OutValid(OutValid), .OutReady(OutReady),
        .Sum(Sum), .CarryOut(CarryOut), .Overflow(Overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated beat, entered and left on a falling edge with an empty pipe.
    task automatic beat(input logic [63:0] x, input logic [63:0] y, input logic cin,
                        input logic sub, input logic [63:0] eSum, input logic eCo,
                        input logic eOv, input string tag);
        X = x; Y = y; CarryIn = cin; Sub = sub; InValid = 1'b1; OutReady = 1'b1;
        #1 check({tag, "_inready"}, InReady, 1);
        @(negedge Clock); InValid = 1'b0;
        @(negedge Clock);
        @(negedge Clock); check({tag, "_early"}, OutValid, 0);
        @(negedge Clock);
        check({tag, "_valid"}, OutValid, 1);
        check({tag, "_sum"}, Sum, eSum);
        check({tag, "_cout"}, CarryOut, eCo);
        check({tag, "_ovf"}, Overflow, eOv);
        @(negedge Clock); check({tag, "_drained"}, OutValid, 0);
    endtask

    initial begin
        int           sent;
        int           got;
        logic         prevStall;
        logic [63:0]  prevSum;
        bit           pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        #12;
        check("rst_outvalid", OutValid, 0);
        check("rst_sum", Sum, 0);
        check("rst_cout", CarryOut, 0);
        check("rst_ovf", Overflow, 0);
        check("rst_inready", InReady, 0);

        @(negedge Clock); ResetN = 1'b1;
        #1 check("release_inready", InReady, 1);

        beat(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'd1, 1'b1, 1'b1, "msb");
        @(negedge Clock);
        beat(64'd231, 64'd698, 1'b0, 1'b0, 64'd929, 1'b0, 1'b0, "small");
        beat(64'hFFFF, 64'd1, 1'b0, 1'b0, 64'h1_0000, 1'b0, 1'b0, "xchunk");
        beat(64'd5, 64'd3, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0, "sub_pos");
        beat(64'd3, 64'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        beat(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "pos_ovf");

        // Streaming: ten beats X=Y=i with OutReady cycling 1,0,0,1.
        Sub = 1'b0; CarryIn = 1'b0;
        sent = 0; got = 0; prevStall = 1'b0; prevSum = '0;
        for (int c = 0; c < 80 && got < 10; c++) begin
            @(negedge Clock);
            OutReady = pat[c % 4];
            InValid  = (sent < 10);
            X = 64'(sent); Y = 64'(sent);
            #1;
            if (prevStall) begin
                check("stall_valid", OutValid, 1);
                check("stall_sum", Sum, prevSum);
            end
            check("stream_inready", InReady, !((sent - got) == 4 && !OutReady));
            if (OutValid && OutReady) begin
                check("stream_sum", Sum, 64'(2*got));
                got++;
            end
            prevStall = OutValid && !OutReady;
            prevSum   = Sum;
            if (InValid && InReady) sent++;
        end
        check("stream_count", 64'(got), 64'd10);
        InValid = 1'b0; OutReady = 1'b1;

        // Reset with three beats in flight, the oldest already presented.
        @(negedge Clock); InValid = 1'b1; X = 64'd100; Y = 64'd0;
        @(negedge Clock); X = 64'd101;
        @(negedge Clock); X = 64'd102;
        @(negedge Clock); InValid = 1'b0;
        @(negedge Clock);
        #1 check("pre_rst_valid", OutValid, 1);
        check("pre_rst_sum", Sum, 64'd100);
        ResetN = 1'b0;
        #1 check("mid_rst_outvalid", OutValid, 0);
        check("mid_rst_sum", Sum, 0);
        check("mid_rst_inready", InReady, 0);
        @(negedge Clock); ResetN = 1'b1;
        #1 check("post_rst_inready", InReady, 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            #1 check("no_stale", OutValid, 0);
        end
        @(negedge Clock);
        beat(64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
